count_sequencer: RTL and testbench

//   FSM controller that sequences a rate-divided hex counter: start, pause, abort, terminal detect.

---
 rtl/count_sequencer.sv | 131 +++++++++++++
 tb/tb_count_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Start/pause/abort sequencer for a rate-divided hex counter with terminal-count detect.
// Define AUTO_RELOAD_EN to wrap at the terminal count and keep running instead of parking in DONE.
module count_sequencer #(
  parameter int CNT_W    = 4,
  parameter int DIV_W    = 26,
  parameter int BASE_DIV = 50000000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [1:0]       speed_sel,
  input  logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

`ifdef AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           st;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       spd_q;
  logic [CNT_W-1:0] tgt_q;
  logic [CNT_W-1:0] count_inc;
  logic             terminal;

  // Reload values wider than DIV_W are truncated to the register width.
  function automatic logic [DIV_W-1:0] reload(input logic [1:0] sel);
    case (sel)
      2'b00:   reload = '0;
      2'b01:   reload = DIV_W'(BASE_DIV - 1);
      2'b10:   reload = DIV_W'(2 * BASE_DIV - 1);
      default: reload = DIV_W'(4 * BASE_DIV - 1);
    endcase
  endfunction

  assign state     = st;
  assign count_inc = count + CNT_W'(1);
  assign terminal  = (count_inc == tgt_q) || (AUTO_RELOAD && (tgt_q == '0));

  // Abort and reset must suppress the strobe in the very cycle they are seen.
  assign tick = reset_n && !abort && (st == S_RUN) && (div_q == '0) && !pause;

  // NOTE: every register here uses <= so all updates see the pre-edge values of each other.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      st    <= S_IDLE;
      count <= '0;
      div_q <= '0;
      spd_q <= '0;
      tgt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (abort) begin
      st    <= S_IDLE;
      count <= '0;
      div_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (st)
        S_IDLE, S_DONE: begin
          if (start) begin
            st    <= S_ARM;
            spd_q <= speed_sel;
            tgt_q <= target;
            count <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        S_ARM: begin
          div_q <= reload(spd_q);
          if (!AUTO_RELOAD && (tgt_q == '0)) begin
            st   <= S_DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            st <= S_RUN;
          end
        end
        S_RUN: begin
          done <= 1'b0;
          if (pause) begin
            st <= S_HOLD;
          end else if (div_q != '0) begin
            div_q <= div_q - DIV_W'(1);
          end else begin
            div_q <= reload(spd_q);
            if (terminal && AUTO_RELOAD) begin
              count <= '0;
              done  <= 1'b1;
            end else if (terminal) begin
              count <= count_inc;
              st    <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              count <= count_inc;
            end
          end
        end
        S_HOLD: begin
          if (!pause) st <= S_RUN;
        end
        default: begin
          st   <= S_IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: cycle-level reference model compared every cycle, plus directed literal checks.
// Build with AUTO_RELOAD_EN defined to exercise the wrapping variant.
module tb_count_sequencer;

  localparam int CNT_W    = 4;
  localparam int DIV_W    = 26;
  localparam int BASE_DIV = 4;

`ifdef AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset_n;
  logic             start;
  logic             pause;
  logic             abort;
  logic [1:0]       speed_sel;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] count;
  logic             tick;
  logic             busy;
  logic             done;
  logic [2:0]       state;

  count_sequencer #(.CNT_W(CNT_W), .DIV_W(DIV_W), .BASE_DIV(BASE_DIV)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pause(pause), .abort(abort),
    .speed_sel(speed_sel), .target(target), .count(count), .tick(tick),
    .busy(busy), .done(done), .state(state)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0..4 = idle/arm/run/hold/done; wait_left = run cycles until the next advance.
  int m_phase = 0, m_count = 0, m_wait = 0, m_tgt = 0, m_spd = 0;
  bit m_pulse = 0;

  function automatic int period(input int sel);
    return (sel == 0) ? 1 : BASE_DIV * (1 << (sel - 1));
  endfunction

  function automatic bit exp_tick();
    return reset_n && !abort && (m_phase == 2) && (m_wait == 0) && !pause;
  endfunction

  always @(posedge clock) begin
    m_pulse = 1'b0;
    if (!reset_n) begin
      m_phase = 0; m_count = 0; m_wait = 0; m_tgt = 0; m_spd = 0;
    end else if (abort) begin
      m_phase = 0; m_count = 0; m_wait = 0;
    end else begin
      case (m_phase)
        0, 4: if (start) begin
          m_phase = 1; m_tgt = int'(target); m_spd = int'(speed_sel); m_count = 0;
        end
        1: begin
          m_wait  = period(m_spd) - 1;
          m_phase = (m_tgt == 0 && !AUTO) ? 4 : 2;
        end
        2: begin
          if (pause) m_phase = 3;
          else if (m_wait > 0) m_wait--;
          else begin
            m_wait  = period(m_spd) - 1;
            m_count = (m_count + 1) % (1 << CNT_W);
            if (AUTO && (m_tgt == 0 || m_count == m_tgt)) begin
              m_count = 0;
              m_pulse = 1'b1;
            end else if (!AUTO && m_count == m_tgt) begin
              m_phase = 4;
            end
          end
        end
        3: if (!pause) m_phase = 2;
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      check("model_state", 32'(state), 32'(m_phase));
      check("model_count", 32'(count), 32'(m_count));
      check("model_busy",  32'(busy),  32'(m_phase >= 1 && m_phase <= 3));
      check("model_done",  32'(done),  32'(AUTO ? m_pulse : (m_phase == 4)));
      check("model_tick",  32'(tick),  32'(exp_tick()));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic go(input logic [1:0] sel, input logic [CNT_W-1:0] tgt);
    speed_sel = sel; target = tgt; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    speed_sel = 2'b00; target = '0;
    cyc();
    checking = 1'b1;
    cyc();
    reset_n = 1'b1;
    @(negedge clock);
    check("reset_state", 32'(state), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_flags", {29'd0, busy, done, tick}, 32'd0);

`ifndef AUTO_RELOAD_EN
    // Speed 00, target 5: advance every RUN cycle, count 0..4 seen before each tick.
    go(2'b00, 4'd5);
    @(negedge clock);
    check("a_arm_state", 32'(state), 32'd1);
    check("a_arm_busy",  32'(busy),  32'd1);
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("a_run_count", 32'(count), 32'(i));
      check("a_run_tick",  32'(tick),  32'd1);
      cyc();
    end
    @(negedge clock);
    check("a_done_state", 32'(state), 32'd4);
    check("a_done_count", 32'(count), 32'd5);
    check("a_done_flags", {30'd0, busy, done}, 32'd1);

    // Speed 01, target 2: ticks on RUN cycles 4 and 8, DONE afterwards.
    go(2'b01, 4'd2);
    @(negedge clock);
    check("b_arm_state", 32'(state), 32'd1);
    cyc();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      check("b_tick", 32'(tick), 32'(k % 4 == 0));
      cyc();
    end
    @(negedge clock);
    check("b_done_state", 32'(state), 32'd4);
    check("b_done_count", 32'(count), 32'd2);

    // Speed 01, target 3: pause for 10 cycles after the first tick.
    go(2'b01, 4'd3);
    cyc();
    repeat (4) cyc();
    @(negedge clock);
    check("c_pre_pause_count", 32'(count), 32'd1);
    pause = 1'b1;
    cyc();
    @(negedge clock);
    check("c_hold_state", 32'(state), 32'd3);
    repeat (9) cyc();
    @(negedge clock);
    check("c_hold_state_end", 32'(state), 32'd3);
    check("c_hold_count_end", 32'(count), 32'd1);
    pause = 1'b0;
    for (int n = 0; n < 60 && state != 3'd4; n++) cyc();
    @(negedge clock);
    check("c_done_state", 32'(state), 32'd4);
    check("c_done_count", 32'(count), 32'd3);

    // Abort with a simultaneous start in RUN at count 3.
    go(2'b00, 4'd9);
    cyc();
    repeat (3) cyc();
    @(negedge clock);
    check("d_count_before_abort", 32'(count), 32'd3);
    abort = 1'b1; start = 1'b1;
    @(negedge clock);
    check("d_abort_no_tick", 32'(tick), 32'd0);
    cyc();
    abort = 1'b0;
    @(negedge clock);
    check("d_abort_state", 32'(state), 32'd0);
    check("d_abort_count", 32'(count), 32'd0);
    cyc();
    start = 1'b0;
    @(negedge clock);
    check("d_restart_state", 32'(state), 32'd1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;

    // Target 0: ARM straight to DONE with no tick.
    go(2'b00, 4'd0);
    @(negedge clock);
    check("e_arm_tick", 32'(tick), 32'd0);
    cyc();
    @(negedge clock);
    check("e_done_state", 32'(state), 32'd4);
    check("e_done_flags", {27'd0, count, done}, 32'd1);
`else
    // Speed 00, target 3: count 0,1,2 then wraps to 0 with a one-cycle done pulse.
    go(2'b00, 4'd3);
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("ar_count", 32'(count), 32'((i == 3) ? 0 : i % 3));
      check("ar_done",  32'(done),  32'(i == 3));
      cyc();
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    // Target 0 keeps running, count pinned at 0, done on every advance.
    go(2'b00, 4'd0);
    cyc();
    @(negedge clock);
    check("ar0_run_state", 32'(state), 32'd2);
    cyc();
    @(negedge clock);
    check("ar0_done", {27'd0, count, done}, 32'd1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
`endif

    // Synchronous reset in the middle of a RUN.
    go(2'b01, 4'd5);
    cyc();
    repeat (5) cyc();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    @(negedge clock);
    check("f_reset_state", 32'(state), 32'd0);
    check("f_reset_outs", {27'd0, count, busy, done, tick}, 32'd0);
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
